tw_gen_seq: RTL and testbench
=============================

Name: tw_gen_seq

Overview:
- Sequential, parametrised twiddle-factor generator for the radix-2 DIF FFT datapath.
- On a start command for a given stage, it streams W_M^k = cos(2πk/M) − j·sin(2πk/M) for k = 0 … M/2−1, where M = N >> stage.
- Output uses a valid/ready handshake.
- Replaces the per-butterfly combinational power-of-two divider and LUT pair with one stage-indexed address counter and a shared quarter-wave ROM.

Parameters:
- LOG2N, 8, log2 of the FFT size N; legal range 3..10.
- TW_W, 16, signed twiddle width; unity is represented as 2^(TW_W−2).
- STG_W, 4, width of stage_idx; must satisfy 2^STG_W ≥ LOG2N.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to generate one stage's twiddles
- stage_idx  in  STG_W  DIF stage s (0 = first stage, M = N); sampled with start
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse after the last twiddle is accepted
- err  out  1  one-cycle pulse when start is rejected because stage_idx ≥ LOG2N
- tw_valid  out  1  tw_* outputs are valid
- tw_ready  in  1  consumer accepts when tw_valid & tw_ready
- tw_k  out  LOG2N−1  index k of the current twiddle
- tw_real  out  TW_W  signed cos term
- tw_img  out  TW_W  signed −sin term
- tw_last  out  1  high with the final twiddle of the stage (k = M/2−1)

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - state = IDLE.
  - busy, done, err, tw_valid, tw_last = 0.
  - tw_k, tw_real, tw_img = 0.
  - Reset mid-RUN aborts immediately. No done pulse is produced and there is no residual output.
- States: IDLE, RUN, FIN.
- IDLE:
  - start with stage_idx < LOG2N: latch s, set k = 0, load output register with W(0) on the same edge; next state RUN.
  - Result: busy and tw_valid rise one cycle after start.
  - start with stage_idx ≥ LOG2N: err pulses for 1 cycle; remain IDLE.
- RUN:
  - On fire (tw_valid & tw_ready) with tw_last = 0: k ← k+1 and the output register is loaded with W(k+1) on the same edge. This gives one twiddle per cycle under continuous ready.
  - Without fire: all tw_* outputs hold stable. This is a hard AXI-style rule: no change while valid & !ready.
  - On fire with tw_last = 1: tw_valid ← 0; next state FIN.
- FIN: done = 1 for one cycle, busy ← 0; next state IDLE.
- start is ignored while busy. It is not queued and does not abort.
- Latency and throughput:
  - start to first valid: 1 cycle.
  - Last fire to done: 1 cycle.
  - Stage s emits M/2 = 2^(LOG2N−1−s) twiddles.
  - Last stage (M = 2): a single twiddle, k = 0, with tw_last set on it.
- Addressing: phase index p = k << s, with 0 ≤ p < N/2. The address is computed at LOG2N−1 bits; no overflow is possible because k < M/2.
- ROM: quarter-wave sine table Q[i] = round(2^(TW_W−2) · sin(2πi/N)) for i = 0 … N/4. Round half away from zero.
  - p ≤ N/4: cos = Q[N/4−p], sin = Q[p].
  - p > N/4: cos = −Q[p−N/4], sin = Q[N/2−p].
  - Outputs: tw_real = cos, tw_img = −sin.
  - Negation never overflows because |Q| ≤ 2^(TW_W−2).
- ROM lookup is combinational and folded into the output register load, so there is no extra pipeline stage.

Decomposition:
- Shared package: state encoding (IDLE/RUN/FIN), unity constant ONE = 2^(TW_W−2), and helper functions for address width and quarter-index folding.
- One sub-module, tw_qrom: purely combinational, parameters LOG2N and TW_W.
  - Input: index i (LOG2N−2+1 bits).
  - Output: Q[i].
  - Contents are generated at elaboration; no external memory file.
- The top level holds the FSM, the k counter, the symmetry fold/sign logic and the output register.

Test Plan:
- Reset, then start with s = 0, N = 256, tw_ready held at 1:
  - 128 twiddles on consecutive cycles.
  - k = 0 → (16384, 0); k = 32 → (11585, −11585); k = 64 → (0, −16384); k = 96 → (−11585, −11585); k = 127 → (−16379, −402).
  - tw_last on k = 127; done pulses one cycle later.
- Start with s = 7 (M = 2): exactly one twiddle (16384, 0) with tw_last = 1; done follows; busy is high for 2 cycles.
- s = 5 (M = 8) with tw_ready toggled pseudo-randomly:
  - Sequence k = 0..3 equals p = 0, 32, 64, 96 values.
  - Outputs stay stable across every stalled cycle.
  - No k is skipped or duplicated.
- start with stage_idx = 8 (≥ LOG2N): err pulses; busy, tw_valid and done stay 0. A start while busy is ignored, and the current stream completes unchanged.
- Assert rst_n low mid-RUN at k = 10 of s = 1: all outputs are 0 asynchronously; no done pulse; a fresh start afterwards begins at k = 0.
- Re-parametrise LOG2N = 4, TW_W = 12 (unity = 1024), s = 0: emits (1024, 0), (946, −392), (724, −724), (392, −946), (0, −1024), (−392, −946), (−724, −724), (−946, −392).

Source files
------------

// File: rtl/tw_gen_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tw_gen_seq_pkg
// Description : Shared types and helpers for the sequential twiddle generator.
//               State encoding, unity constant and the quarter-wave
//               index folding used to map a phase index onto the ROM.
// Revision    : 1.0 - initial release
// ============================================================================
package tw_gen_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } tw_state_e;

    // Unity magnitude: 2^(TW_W-2) leaves one guard bit above the sign.
    function automatic int tw_one(input int tw_w);
        return 1 << (tw_w - 2);
    endfunction

    // Phase index p = k << s spans 0 .. N/2-1.
    function automatic int tw_addr_w(input int log2n);
        return log2n - 1;
    endfunction

    function automatic int tw_quarter(input int log2n);
        return 1 << (log2n - 2);
    endfunction

    // ROM index holding |cos(2*pi*p/N)|.
    function automatic int tw_fold_cos(input int p, input int log2n);
        int q;
        q = tw_quarter(log2n);
        return (p <= q) ? (q - p) : (p - q);
    endfunction

    // ROM index holding sin(2*pi*p/N), which is never negative for p < N/2.
    function automatic int tw_fold_sin(input int p, input int log2n);
        int q;
        q = tw_quarter(log2n);
        return (p <= q) ? p : (2 * q - p);
    endfunction

endpackage
`default_nettype wire

// File: rtl/tw_qrom.sv
`default_nettype none
// ============================================================================
// Module      : tw_qrom
// Description : Combinational quarter-wave sine table,
//               Q[i] = round(2^(TW_W-2) * sin(2*pi*i/N)), i = 0 .. N/4.
//               Contents are computed at elaboration.
// Ports       : idx - table index (LOG2N-1 bits)
//               q   - signed table value (TW_W bits), 0 for idx > N/4
// Revision    : 1.0 - initial release
// ============================================================================
module tw_qrom
    import tw_gen_seq_pkg::*;
#(
    parameter int LOG2N = 8,
    parameter int TW_W  = 16
) (
    input  logic [LOG2N-2:0]       idx,
    output logic signed [TW_W-1:0] q
);

    localparam int  c_qn     = tw_quarter(LOG2N);
    localparam real c_two_pi = 6.283185307179586;
    localparam real c_scale  = 1.0 * tw_one(TW_W);

    logic signed [TW_W-1:0] w_table [0:c_qn];

    for (genvar gi = 0; gi <= c_qn; gi++) begin : g_entry
        localparam real c_val_r = c_scale * $sin(c_two_pi * gi / (4.0 * c_qn));
        // Entries are non-negative, so +0.5 then truncate rounds half away from zero.
        localparam int  c_val   = $rtoi(c_val_r + 0.5);
        assign w_table[gi] = TW_W'(c_val);
    end

    always_comb begin
        q = '0;
        if (32'(idx) <= c_qn) begin
            q = w_table[idx];
        end
    end

endmodule
`default_nettype wire

// File: rtl/tw_gen_seq.sv
`default_nettype none
// ============================================================================
// Module      : tw_gen_seq
// Description : Sequential radix-2 DIF twiddle generator. On start for stage
//               s it streams W_M^k, k = 0 .. M/2-1 with M = N >> s, over a
//               valid/ready handshake, using one quarter-wave ROM.
// Ports       : clk, rst_n          - clock, async active-low reset
//               start, stage_idx    - stage request (sampled together)
//               busy, done, err     - status (done/err are 1-cycle pulses)
//               tw_valid, tw_ready  - output handshake
//               tw_k, tw_real, tw_img, tw_last - twiddle index/value/last flag
// Revision    : 1.0 - initial release
// ============================================================================
module tw_gen_seq
    import tw_gen_seq_pkg::*;
#(
    parameter int LOG2N = 8,
    parameter int TW_W  = 16,
    parameter int STG_W = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [STG_W-1:0]       stage_idx,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic                   tw_valid,
    input  logic                   tw_ready,
    output logic [LOG2N-2:0]       tw_k,
    output logic signed [TW_W-1:0] tw_real,
    output logic signed [TW_W-1:0] tw_img,
    output logic                   tw_last
);

    localparam int               c_aw      = tw_addr_w(LOG2N);
    localparam logic [c_aw-1:0]  c_quarter = c_aw'(tw_quarter(LOG2N));
    localparam logic [STG_W:0]   c_log2n   = LOG2N[STG_W:0];

    tw_state_e r_state, w_state_nxt;

    logic                   r_valid, r_last, r_err;
    logic [c_aw-1:0]        r_k;
    logic [STG_W-1:0]       r_s;
    logic signed [TW_W-1:0] r_real, r_img;

    logic                   w_fire, w_load, w_first, w_err_set, w_valid_nxt;
    logic [c_aw-1:0]        w_k_sel, w_p, w_last_k;
    logic [STG_W-1:0]       w_s_sel;
    logic [c_aw-1:0]        w_cos_idx, w_sin_idx;
    logic                   w_cos_neg;
    logic signed [TW_W-1:0] w_q_cos, w_q_sin, w_cos, w_nsin;

    assign w_fire = r_valid & tw_ready;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_first     = 1'b0;
        w_err_set   = 1'b0;
        w_valid_nxt = r_valid;
        unique case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if ({1'b0, stage_idx} >= c_log2n) begin
                        w_err_set = 1'b1;
                    end else begin
                        w_load      = 1'b1;
                        w_first     = 1'b1;
                        w_valid_nxt = 1'b1;
                        w_state_nxt = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (w_fire) begin
                    if (r_last) begin
                        w_valid_nxt = 1'b0;
                        w_state_nxt = ST_FIN;
                    end else begin
                        w_load = 1'b1;
                    end
                end
            end
            ST_FIN: begin
                w_valid_nxt = 1'b0;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_valid_nxt = 1'b0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Address generation: the next twiddle is looked up combinationally
    // so that it lands in the output register on the same edge as k moves.
    // ------------------------------------------------------------------
    assign w_k_sel  = w_first ? '0 : (r_k + c_aw'(1));
    assign w_s_sel  = w_first ? stage_idx : r_s;
    assign w_p      = w_k_sel << w_s_sel;
    assign w_last_k = {c_aw{1'b1}} >> w_s_sel;   // M/2 - 1

    always_comb begin
        w_cos_idx = c_aw'(tw_fold_cos(32'(w_p), LOG2N));
        w_sin_idx = c_aw'(tw_fold_sin(32'(w_p), LOG2N));
        w_cos_neg = (w_p > c_quarter);
    end

    tw_qrom #(
        .LOG2N (LOG2N),
        .TW_W  (TW_W)
    ) u_rom_cos (
        .idx (w_cos_idx),
        .q   (w_q_cos)
    );

    tw_qrom #(
        .LOG2N (LOG2N),
        .TW_W  (TW_W)
    ) u_rom_sin (
        .idx (w_sin_idx),
        .q   (w_q_sin)
    );

    assign w_cos  = w_cos_neg ? -w_q_cos : w_q_cos;
    assign w_nsin = -w_q_sin;

    // ------------------------------------------------------------------
    // Output register: only changes on load, so stalled outputs hold.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            r_last  <= 1'b0;
            r_k     <= '0;
            r_s     <= '0;
            r_real  <= '0;
            r_img   <= '0;
        end else begin
            r_valid <= w_valid_nxt;
            r_err   <= w_err_set;
            if (w_first) begin
                r_s <= stage_idx;
            end
            if (w_load) begin
                r_k    <= w_k_sel;
                r_real <= w_cos;
                r_img  <= w_nsin;
                r_last <= (w_k_sel == w_last_k);
            end
        end
    end

    assign busy     = (r_state != ST_IDLE);
    assign done     = (r_state == ST_FIN);
    assign err      = r_err;
    assign tw_valid = r_valid;
    assign tw_k     = r_k;
    assign tw_real  = r_real;
    assign tw_img   = r_img;
    assign tw_last  = r_last;

endmodule
`default_nettype wire

// File: tb/tb_tw_gen_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_tw_gen_seq
// Description : Scoreboard bench for tw_gen_seq. Expected twiddles come from
//               cos/sin of the phase angle; a monitor pops them on each fire.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tw_gen_seq;

    localparam int  N    = 256;
    localparam int  ONE  = 16384;
    localparam real c_pi = 3.14159265358979323846;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  stage_idx = '0;
    logic        tw_ready = 1'b1;
    logic        busy, done, err, tw_valid, tw_last;
    logic [6:0]  tw_k;
    logic signed [15:0] tw_real, tw_img;

    logic        start_b = 1'b0;
    logic [3:0]  stage_b = '0;
    logic        ready_b = 1'b1;
    logic        busy_b, done_b, err_b, valid_b, last_b;
    logic [2:0]  k_b;
    logic signed [11:0] re_b, im_b;

    tw_gen_seq #(.LOG2N(8), .TW_W(16), .STG_W(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stage_idx(stage_idx),
        .busy(busy), .done(done), .err(err), .tw_valid(tw_valid),
        .tw_ready(tw_ready), .tw_k(tw_k), .tw_real(tw_real),
        .tw_img(tw_img), .tw_last(tw_last)
    );

    tw_gen_seq #(.LOG2N(4), .TW_W(12), .STG_W(4)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .stage_idx(stage_b),
        .busy(busy_b), .done(done_b), .err(err_b), .tw_valid(valid_b),
        .tw_ready(ready_b), .tw_k(k_b), .tw_real(re_b),
        .tw_img(im_b), .tw_last(last_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        int k;
        int re;
        int im;
        bit last;
    } tw_t;

    tw_t q_a[$];
    tw_t q_b[$];
    int  n_vec = 0;
    int  n_err = 0;
    bit  rdy_rand = 1'b0;
    int  cap_re[128];
    int  cap_im[128];

    task automatic chk(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int rnd(input real x);
        if (x >= 0.0) return $rtoi(x + 0.5);
        else          return -$rtoi(-x + 0.5);
    endfunction

    // Reference: W = cos(2*pi*p/N) - j*sin(2*pi*p/N), p = k * 2^s.
    task automatic push_stage(input int s);
        int  m2;
        real ang;
        tw_t e;
        m2 = (N / 2) >> s;
        for (int k = 0; k < m2; k++) begin
            ang    = 2.0 * c_pi * real'(k * (1 << s)) / real'(N);
            e.k    = k;
            e.re   = rnd(real'(ONE) * $cos(ang));
            e.im   = rnd(-real'(ONE) * $sin(ang));
            e.last = (k == m2 - 1);
            q_a.push_back(e);
        end
    endtask

    task automatic issue(input int s);
        @(posedge clk); #1;
        start     = 1'b1;
        stage_idx = 4'(s);
        push_stage(s);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("start_busy", busy, 1);
        chk("start_valid", tw_valid, 1);
        chk("start_k", tw_k, 0);
    endtask

    task automatic finish(input int s, input bit full_rate);
        int cyc, bcnt;
        bit got;
        cyc = 0; bcnt = 1; got = 1'b0;
        while (!got && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            if (busy) bcnt++;
            if (done) got = 1'b1;
        end
        chk("done_seen", got, 1);
        if (got) begin
            if (full_rate) chk("busy_cycles", bcnt, ((N / 2) >> s) + 1);
            chk("queue_drained", q_a.size(), 0);
            @(negedge clk);
            chk("busy_after_done", busy, 0);
            chk("done_one_cycle", done, 0);
        end
    endtask

    // Ready driver
    initial begin
        forever begin
            @(posedge clk); #1;
            tw_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor for the N = 256 instance
    initial begin : mon_a
        bit     stall, exp_done;
        longint snap;
        tw_t    e;
        stall = 1'b0; exp_done = 1'b0; snap = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall    = 1'b0;
                exp_done = 1'b0;
            end else begin
                chk("done_timing", done, exp_done);
                if (stall) chk("stall_hold", {tw_valid, tw_k, tw_real, tw_img, tw_last}, snap);
                exp_done = tw_valid && tw_ready && tw_last;
                if (tw_valid && tw_ready) begin
                    if (q_a.size() == 0) begin
                        n_vec++; n_err++;
                        $display("FAIL unexpected_tw: got k=%0d, expected no output", tw_k);
                    end else begin
                        e = q_a.pop_front();
                        chk("tw_k", tw_k, e.k);
                        chk("tw_real", tw_real, e.re);
                        chk("tw_img", tw_img, e.im);
                        chk("tw_last", tw_last, e.last);
                        cap_re[tw_k] = tw_real;
                        cap_im[tw_k] = tw_img;
                    end
                end
                stall = tw_valid && !tw_ready;
                snap  = {tw_valid, tw_k, tw_real, tw_img, tw_last};
            end
        end
    end

    // Monitor for the N = 16 instance
    initial begin : mon_b
        tw_t e;
        forever begin
            @(negedge clk);
            if (rst_n && valid_b && ready_b) begin
                if (q_b.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL b_unexpected_tw: got k=%0d, expected no output", k_b);
                end else begin
                    e = q_b.pop_front();
                    chk("b_tw_k", k_b, e.k);
                    chk("b_tw_real", re_b, e.re);
                    chk("b_tw_img", im_b, e.im);
                    chk("b_tw_last", last_b, e.last);
                end
            end
        end
    end

    initial begin : main
        int  s, cyc;
        bit  got;
        tw_t e;
        int  b_re[8];
        int  b_im[8];
        b_re = '{1024, 946, 724, 392, 0, -392, -724, -946};
        b_im = '{0, -392, -724, -946, -1024, -946, -724, -392};

        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_valid", tw_valid, 0);
        chk("rst_k", tw_k, 0);
        chk("rst_real", tw_real, 0);
        chk("rst_img", tw_img, 0);
        chk("rst_last", tw_last, 0);
        rst_n = 1'b1;

        // Full stage 0 at full rate, plus spot values
        rdy_rand = 1'b0;
        issue(0);
        finish(0, 1'b1);
        chk("s0_k0_re", cap_re[0], 16384);     chk("s0_k0_im", cap_im[0], 0);
        chk("s0_k32_re", cap_re[32], 11585);   chk("s0_k32_im", cap_im[32], -11585);
        chk("s0_k64_re", cap_re[64], 0);       chk("s0_k64_im", cap_im[64], -16384);
        chk("s0_k96_re", cap_re[96], -11585);  chk("s0_k96_im", cap_im[96], -11585);
        chk("s0_k127_re", cap_re[127], -16379); chk("s0_k127_im", cap_im[127], -402);

        // Last stage: single twiddle
        issue(7);
        finish(7, 1'b1);

        // Stage 5 with random back-pressure
        rdy_rand = 1'b1;
        issue(5);
        finish(5, 1'b0);

        // Illegal stages
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            start     = 1'b1;
            stage_idx = (i == 0) ? 4'd8 : 4'd15;
            @(posedge clk); #1;
            start = 1'b0;
            @(negedge clk);
            chk("err_pulse", err, 1);
            chk("err_busy", busy, 0);
            chk("err_valid", tw_valid, 0);
            @(negedge clk);
            chk("err_clear", err, 0);
            chk("err_idle_busy", busy, 0);
        end

        // Start while busy is ignored
        issue(3);
        @(posedge clk); #1;
        start     = 1'b1;
        stage_idx = 4'd0;
        @(posedge clk); #1;
        start = 1'b0;
        finish(3, 1'b0);
        repeat (3) begin
            @(negedge clk);
            chk("idle_no_valid", tw_valid, 0);
        end

        // Reset mid-run at k = 10 of stage 1
        rdy_rand = 1'b0;
        issue(1);
        cyc = 0;
        while (tw_k != 7'd10 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("reach_k10", tw_k, 10);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_err", err, 0);
        chk("arst_valid", tw_valid, 0);
        chk("arst_k", tw_k, 0);
        chk("arst_real", tw_real, 0);
        chk("arst_img", tw_img, 0);
        chk("arst_last", tw_last, 0);
        q_a.delete();
        repeat (2) @(negedge clk);
        chk("arst_no_done", done, 0);
        rst_n = 1'b1;
        issue(1);
        finish(1, 1'b1);

        // Random stages under random back-pressure
        rdy_rand = 1'b1;
        repeat (6) begin
            s = $urandom_range(0, 7);
            issue(s);
            finish(s, 1'b0);
        end
        rdy_rand = 1'b0;

        // Small instance: N = 16, TW_W = 12
        for (int k = 0; k < 8; k++) begin
            e.k = k; e.re = b_re[k]; e.im = b_im[k]; e.last = (k == 7);
            q_b.push_back(e);
        end
        @(posedge clk); #1;
        start_b = 1'b1;
        stage_b = 4'd0;
        @(posedge clk); #1;
        start_b = 1'b0;
        cyc = 0; got = 1'b0;
        while (!got && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (done_b) got = 1'b1;
        end
        chk("b_done_seen", got, 1);
        chk("b_queue_drained", q_b.size(), 0);
        chk("b_err", err_b, 0);
        @(negedge clk);
        chk("b_busy_after_done", busy_b, 0);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
